// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the serial adder/subtractor.
package serial_addsub_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;
endpackage

// File: rtl/serial_addsub_slice.sv
// Combinational STEP-bit ripple-carry slice used once per clock by serial_addsub.
// c_msb is the carry into the top bit of the slice; on the final step of an
// operation that is the carry into the operand MSB, used for overflow.
module addsub_slice #(
    parameter int STEP = 1
) (
    input  logic [STEP-1:0] a,
    input  logic [STEP-1:0] b,
    input  logic            cin,
    output logic [STEP-1:0] s,
    output logic            cout,
    output logic            c_msb
);
    logic [STEP:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < STEP; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end

    assign cout  = c[STEP];
    assign c_msb = c[STEP-1];
endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle N-bit adder/subtractor, STEP bits per clock, LSB first.
// Optional feature macro: SERIAL_ADDSUB_OVF_EN builds the signed-overflow
// logic; without it ovf is tied to 0.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             a_ns,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int N  = WIDTH / STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [STEP-1:0]       sum;
    logic                  c_out, c_msb;
    logic [WIDTH+STEP-1:0] res_cat;
    logic [WIDTH-1:0]      res_next;
    logic                  accept, last;

    addsub_slice #(.STEP(STEP)) u_slice (
        .a     (a_sr[STEP-1:0]),
        .b     (b_sr[STEP-1:0]),
        .cin   (carry),
        .s     (sum),
        .cout  (c_out),
        .c_msb (c_msb)
    );

    // New sum bits enter at the MSB end so the result is assembled LSB-first.
    assign res_cat  = {sum, res_sr};
    assign res_next = res_cat[WIDTH+STEP-1:STEP];
    assign accept   = start && (state == IDLE || state == DONE);
    assign last     = (state == RUN) && (cnt == LAST);

    // Control FSM, operand/result shift registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            s      <= '0;
            cout   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                // Subtract is A + ~B + 1: invert B and seed the carry with 1.
                state <= RUN;
                busy  <= 1'b1;
                a_sr  <= a;
                b_sr  <= (a_ns == OP_ADD) ? b : ~b;
                carry <= ~a_ns;
                cnt   <= '0;
            end else if (state == RUN) begin
                a_sr   <= a_sr >> STEP;
                b_sr   <= b_sr >> STEP;
                res_sr <= res_next;
                carry  <= c_out;
                cnt    <= cnt + 1'b1;
                if (last) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    s     <= res_next;
                    cout  <= c_out;
                end
            end else if (state == DONE) begin
                state <= IDLE;
            end
        end
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf <= 1'b0;
        else if (last)
            ovf <= c_msb ^ c_out;
    end
`else
    logic unused_c_msb;
    assign unused_c_msb = c_msb;
    assign ovf          = 1'b0;
`endif
endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: one STEP=1 and one STEP=4 instance.
module tb_serial_addsub;
    import serial_addsub_pkg::*;

`ifdef SERIAL_ADDSUB_OVF_EN
    localparam logic OV = 1'b1;
`else
    localparam logic OV = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start1 = 1'b0, op1 = 1'b1;
    logic [7:0] a1 = '0, b1 = '0;
    logic       busy1, done1, cout1, ovf1;
    logic [7:0] s1;

    logic       start4 = 1'b0, op4 = 1'b1;
    logic [7:0] a4 = '0, b4 = '0;
    logic       busy4, done4, cout4, ovf4;
    logic [7:0] s4;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8), .STEP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .a_ns(op1),
        .busy(busy1), .done(done1), .s(s1), .cout(cout1), .ovf(ovf1)
    );

    serial_addsub #(.WIDTH(8), .STEP(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .a_ns(op4),
        .busy(busy4), .done(done4), .s(s4), .cout(cout4), .ovf(ovf4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Count edges until done rises (from cycles already spent), bounded.
    task automatic wait_done(input bit use4, input int already, output int cyc);
        cyc = already;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            cyc++;
            if ((use4 ? done4 : done1) === 1'b1) return;
        end
        cyc = -1;
    endtask

    // Issue one op on dut1, check latency and result.
    task automatic run1(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic op, input logic [7:0] es, input logic ec, input logic eo);
        int cyc;
        a1 = a; b1 = b; op1 = op; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        chk({tag, "_busy"}, busy1, 1);
        wait_done(1'b0, 0, cyc);
        chk({tag, "_lat"}, cyc, 8);
        chk({tag, "_s"}, s1, es);
        chk({tag, "_cout"}, cout1, ec);
        chk({tag, "_ovf"}, ovf1, eo);
    endtask

    task automatic run4(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic op, input logic [7:0] es, input logic ec, input logic eo);
        int cyc;
        a4 = a; b4 = b; op4 = op; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        wait_done(1'b1, 0, cyc);
        chk({tag, "_lat"}, cyc, 2);
        chk({tag, "_s"}, s4, es);
        chk({tag, "_cout"}, cout4, ec);
        chk({tag, "_ovf"}, ovf4, eo);
    endtask

    initial begin
        int cyc;
        int extra;

        // Reset state
        #12;
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_s", s1, 8'h00);
        chk("rst_cout", cout1, 0);
        chk("rst_ovf", ovf1, 0);
        chk("rst4_s", s4, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Add with signed overflow: 90 + 51 = 141
        run1("add5a33", 8'h5A, 8'h33, OP_ADD, 8'h8D, 1'b0, OV);
        @(posedge clk); #1;
        chk("done_pulse", done1, 0);
        chk("idle_busy", busy1, 0);
        chk("hold_s", s1, 8'h8D);

        // Subtract with borrow, then subtract with signed overflow
        run1("sub1020", 8'h10, 8'h20, OP_SUB, 8'hF0, 1'b0, 1'b0);
        run1("sub8001", 8'h80, 8'h01, OP_SUB, 8'h7F, 1'b1, OV);

        // start during RUN is ignored
        a1 = 8'h01; b1 = 8'h01; op1 = OP_ADD; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("hold_s_run", s1, 8'h7F);
        a1 = 8'hFF; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        wait_done(1'b0, 3, cyc);
        chk("ign_lat", cyc, 8);
        chk("ign_s", s1, 8'h02);
        chk("ign_cout", cout1, 0);
        chk("ign_ovf", ovf1, 0);
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done1 === 1'b1 || busy1 === 1'b1) extra++;
        end
        chk("ign_no_second", extra, 0);

        // Reset in the middle of RUN
        a1 = 8'h33; b1 = 8'h11; op1 = OP_ADD; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy1, 0);
        chk("mid_rst_done", done1, 0);
        chk("mid_rst_s", s1, 8'h00);
        chk("mid_rst_cout", cout1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done1 === 1'b1 || busy1 === 1'b1) extra++;
        end
        chk("post_rst_idle", extra, 0);

        // Back-to-back: start held high through DONE
        a1 = 8'h05; b1 = 8'h03; op1 = OP_ADD; start1 = 1'b1;
        @(posedge clk); #1;
        a1 = 8'h40; b1 = 8'h40;
        wait_done(1'b0, 0, cyc);
        chk("b2b1_lat", cyc, 8);
        chk("b2b1_s", s1, 8'h08);
        chk("b2b1_ovf", ovf1, 0);
        @(posedge clk); #1;
        start1 = 1'b0;
        chk("b2b_busy", busy1, 1);
        chk("b2b_done", done1, 0);
        wait_done(1'b0, 0, cyc);
        chk("b2b2_lat", cyc, 8);
        chk("b2b2_s", s1, 8'h80);
        chk("b2b2_cout", cout1, 0);
        chk("b2b2_ovf", ovf1, OV);

        // STEP=4 instance
        run4("s4_ff01", 8'hFF, 8'h01, OP_ADD, 8'h00, 1'b1, 1'b0);
        run4("s4_7f01", 8'h7F, 8'h01, OP_ADD, 8'h80, 1'b0, OV);
        run4("s4_0001", 8'h00, 8'h01, OP_SUB, 8'hFF, 1'b0, 1'b0);
        run4("s4_3c15", 8'h3C, 8'h15, OP_SUB, 8'h27, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised, multi-cycle N-bit adder/subtractor that generalises the single-bit full adder/subtractor cell. Operands are loaded on a start handshake and processed LSB-first, STEP bits per clock, with the carry held in a flip-flop between steps. Sits beside the datapath as a low-area arithmetic unit with a start/busy/done handshake and registered result, carry/borrow and signed-overflow outputs.

## Interface
- WIDTH, 8: operand and result width in bits; ≥ 2.
- STEP, 1: bits processed per clock; must divide WIDTH evenly, 1 ≤ STEP ≤ WIDTH.
- clk  input  1  clock, rising-edge active.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; accepted only in IDLE or DONE.
- a  input  WIDTH  operand A; sampled on the accepting edge.
- b  input  WIDTH  operand B; sampled on the accepting edge.
- a_ns  input  1  1 = add (A+B), 0 = subtract (A−B); sampled on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- s  output  WIDTH  result, held until the next completion.
- cout  output  1  carry out; for subtract 1 = no borrow, 0 = borrow.
- ovf  output  1  two's-complement overflow.

## Operation
- Decided: one clock; reset is asynchronous and active-low.
- States: IDLE, RUN, DONE.
  - IDLE → RUN on start.
  - RUN → DONE when the step counter reaches WIDTH/STEP − 1 and that final step completes.
  - DONE → RUN if start is high, else → IDLE.
- Accepting edge actions:
  - Load A into the A shift register.
  - Load B into the B shift register, or ~B when a_ns = 0.
  - Carry flop ← ~a_ns (1 for subtract, 0 for add).
  - Step counter ← 0.
- Each RUN edge:
  - Add the STEP LSBs of both shift registers plus carry.
  - Shift the sum bits into the result shift register from the MSB end.
  - Shift both operand registers right by STEP.
  - Update the carry flop and increment the counter.
- Final step: s ← assembled result; cout ← final carry; ovf ← (carry into MSB) XOR (carry out of MSB).
- s, cout and ovf change only on the final RUN edge. Otherwise they hold, including through IDLE and new RUN phases.
- start during RUN is ignored; no queuing, no error.
- Reset (any time, including mid-RUN):
  - State → IDLE.
  - busy, done, s, cout, ovf → 0.
  - Internal shift registers, carry and counter → 0.

## Timing
- Latency: N = WIDTH/STEP edges.
  - start is sampled high at edge k.
  - busy is high after edges k … k+N−1.
  - Result lands at edge k+N; done is high for exactly the cycle after edge k+N.
- Back-to-back: start high during DONE is accepted at that edge. done drops, busy rises. Throughput is one operation per N cycles.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- SERIAL_ADDSUB_OVF_EN defined:
  - The carry-into-MSB flop and overflow logic are built.
  - ovf is valid per Operation.
- Undefined:
  - The logic is removed and ovf is tied to 0.
  - The port remains; all other behaviour is identical.

## Structure
- Package serial_addsub_pkg holds:
  - state_t enum {IDLE, RUN, DONE};
  - constants OP_ADD = 1'b1, OP_SUB = 1'b0.
- Sub-module addsub_slice: combinational, STEP-bit ripple chain.
  - Inputs: a[STEP], b[STEP], cin.
  - Outputs: s[STEP], cout, c_msb (carry into the top bit).
  - Instantiated once in serial_addsub.

## Test plan
- WIDTH=8, STEP=1, a=0x5A, b=0x33, a_ns=1 → done 8 cycles after accept; s=0x8D, cout=0, ovf=1.
- a=0x10, b=0x20, a_ns=0 → s=0xF0, cout=0 (borrow), ovf=0. Then a=0x80, b=0x01, a_ns=0 → s=0x7F, cout=1, ovf=1.
- start pulsed with a=0xFF at RUN cycle 3 of an operation 0x01+0x01 → ignored; s=0x02, cout=0, exactly one done pulse.
- rst_n low at RUN cycle 4 → immediately busy=0, done=0, s=0x00. After release, state stays IDLE until start.
- WIDTH=8, STEP=4, 0xFF+0x01 → done 2 cycles after accept; s=0x00, cout=1, ovf=0.
- start held high through DONE with new operands → second op accepted at the DONE edge, no idle cycle. With SERIAL_ADDSUB_OVF_EN undefined, ovf stays 0 for all of the above.
